// File: rtl/lock_ctrl_if.sv
// Keypad-side bus of the 4-digit lock controller.
// master: keypad scanner / supervisor; slave: lock_ctrl.
interface lock_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        unlock;
  logic        buzzer;
  logic        lockout;
  logic [2:0]  count;
  logic [2:0]  entry_len;
  logic [15:0] cp;

  modport master (
    output key_valid, key_code,
    input  unlock, buzzer, lockout, count, entry_len, cp
  );

  modport slave (
    input  key_valid, key_code,
    output unlock, buzzer, lockout, count, entry_len, cp
  );
endinterface

// File: rtl/lock_ctrl.sv
// lock_ctrl: sequencing controller for a 4-digit keypad lock.
// Collects BCD digits, checks them against the stored code on ENTER, drives
// the unlock pulse, failure counting with lockout/buzzer, and the three-step
// code-change procedure (old code, new code, confirm).
// Optional: define LOCK_CTRL_TIMEOUT_EN to discard a partial entry after
// TIMEOUT_CYCLES key-free cycles (also aborting a code change).
module lock_ctrl #(
  parameter logic [15:0] DEFAULT_CODE   = 16'h1234,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 20,
  parameter int          OPEN_CYCLES    = 8,
  parameter int          TIMEOUT_CYCLES = 50
) (
  input  logic        clk,
  input  logic        reset,
  lock_ctrl_if.slave  bus
);

  localparam int TMR_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPEN    = 3'd1,
    S_LOCK    = 3'd2,
    S_CHG_OLD = 3'd3,
    S_CHG_NEW = 3'd4,
    S_CHG_CFM = 3'd5
  } state_t;

  state_t             state_q;
  logic [15:0]        entry_q;
  logic [2:0]         entry_len_q;
  logic [2:0]         count_q;
  logic [15:0]        cp_q;
  logic [15:0]        pend_q;
  logic [TMR_W-1:0]   timer_q;
  logic               unlock_q;
  logic               buzzer_q;
  logic               lockout_q;

  logic               is_digit_d;
  logic               is_enter_d;
  logic               is_clear_d;
  logic               is_change_d;
  logic               entry_full_d;
  logic [2:0]         fails_inc_d;
  logic               fail_lock_d;
  logic               timeout_d;

  // Append one BCD digit on the right; the first digit typed ends up in [15:12].
  function automatic logic [15:0] shift_digit(input logic [15:0] e, input logic [3:0] d);
    return {e[11:0], d};
  endfunction

  assign is_digit_d   = bus.key_valid && (bus.key_code <= 4'h9);
  assign is_enter_d   = bus.key_valid && (bus.key_code == 4'hA);
  assign is_clear_d   = bus.key_valid && (bus.key_code == 4'hB);
  assign is_change_d  = bus.key_valid && (bus.key_code == 4'hC);
  assign entry_full_d = (entry_len_q == 3'd4);
  // Failure count saturates at MAX_FAILS.
  assign fails_inc_d  = (count_q >= 3'(MAX_FAILS)) ? count_q : count_q + 3'd1;
  assign fail_lock_d  = (fails_inc_d == 3'(MAX_FAILS));

`ifdef LOCK_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q;
  logic              accepting_d;

  assign accepting_d = (state_q == S_IDLE) || (state_q == S_CHG_OLD) ||
                       (state_q == S_CHG_NEW) || (state_q == S_CHG_CFM);
  // Fires on the TIMEOUT_CYCLES-th consecutive key-free cycle with a partial entry.
  assign timeout_d   = accepting_d && !bus.key_valid && (entry_len_q != 3'd0) &&
                       (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Idle timer: counts key-free cycles while a partial entry is held.
  always_ff @(posedge clk) begin
    if (reset || bus.key_valid || !accepting_d || (entry_len_q == 3'd0) || timeout_d)
      idle_q <= '0;
    else
      idle_q <= idle_q + 1'b1;
  end
`else
  assign timeout_d = 1'b0;
`endif

  // Main sequencer: entry collection, checks, timed OPEN/LOCKOUT, code change.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      entry_q     <= '0;
      entry_len_q <= '0;
      count_q     <= '0;
      cp_q        <= DEFAULT_CODE;
      pend_q      <= '0;
      timer_q     <= '0;
      unlock_q    <= 1'b0;
      buzzer_q    <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      case (state_q)
        // Timer was loaded with N-1, so the output stays high N cycles; keys dropped.
        S_OPEN: begin
          if (timer_q == '0) begin
            state_q  <= S_IDLE;
            unlock_q <= 1'b0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        S_LOCK: begin
          if (timer_q == '0) begin
            state_q   <= S_IDLE;
            buzzer_q  <= 1'b0;
            lockout_q <= 1'b0;
            count_q   <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        // IDLE and the CHG_* states all accept keys into the entry register.
        default: begin
          if (timeout_d) begin
            entry_q     <= '0;
            entry_len_q <= '0;
            state_q     <= S_IDLE;
          end else if (is_digit_d) begin
            if (!entry_full_d) begin
              entry_q     <= shift_digit(entry_q, bus.key_code);
              entry_len_q <= entry_len_q + 3'd1;
            end
          end else if (is_clear_d) begin
            entry_q     <= '0;
            entry_len_q <= '0;
            state_q     <= S_IDLE;
          end else if (is_change_d) begin
            if (state_q == S_IDLE) begin
              entry_q     <= '0;
              entry_len_q <= '0;
              state_q     <= S_CHG_OLD;
            end
          end else if (is_enter_d) begin
            entry_q     <= '0;
            entry_len_q <= '0;
            if (!entry_full_d) begin
              // Short entry: discard; a change in progress is abandoned.
              state_q <= S_IDLE;
            end else begin
              case (state_q)
                S_IDLE, S_CHG_OLD: begin
                  if (entry_q == cp_q) begin
                    if (state_q == S_IDLE) begin
                      state_q  <= S_OPEN;
                      unlock_q <= 1'b1;
                      timer_q  <= TMR_W'(OPEN_CYCLES - 1);
                      count_q  <= '0;
                    end else begin
                      state_q <= S_CHG_NEW;
                    end
                  end else begin
                    count_q <= fails_inc_d;
                    if (fail_lock_d) begin
                      state_q   <= S_LOCK;
                      buzzer_q  <= 1'b1;
                      lockout_q <= 1'b1;
                      timer_q   <= TMR_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                      state_q <= S_IDLE;
                    end
                  end
                end
                S_CHG_NEW: begin
                  pend_q  <= entry_q;
                  state_q <= S_CHG_CFM;
                end
                S_CHG_CFM: begin
                  if (entry_q == pend_q)
                    cp_q <= pend_q;
                  state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.unlock    = unlock_q;
  assign bus.buzzer    = buzzer_q;
  assign bus.lockout   = lockout_q;
  assign bus.count     = count_q;
  assign bus.entry_len = entry_len_q;
  assign bus.cp        = cp_q;

endmodule

// File: doc/lock_ctrl.md
Name: lock_ctrl

Overview:
Sequencing controller for the 4-digit lock. Accepts one keypad key per strobe, assembles a 4-digit entry, and checks it against a stored code on ENTER. It drives the unlock pulse, failure counting, lockout with buzzer, and the code-change procedure. Sits between the keypad scanner and the door actuator and buzzer drivers.

Parameters:
DEFAULT_CODE, 16'h1234, code loaded into the code register on reset (4 BCD digits, digit 1 in [15:12])
MAX_FAILS, 3, consecutive failed checks that trigger lockout (1..7)
LOCKOUT_CYCLES, 20, clock cycles spent in LOCKOUT
OPEN_CYCLES, 8, clock cycles unlock is held high
TIMEOUT_CYCLES, 50, idle cycles before a partial entry is discarded (optional feature only)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
key_valid  input  1  one-cycle strobe, key_code valid
key_code  input  4  0x0-0x9 digit; 0xA ENTER; 0xB CLEAR; 0xC CHANGE; 0xD-0xF ignored
unlock  output  1  high for OPEN_CYCLES after a correct check
buzzer  output  1  high for the whole of LOCKOUT
lockout  output  1  high while in LOCKOUT
count  output  3  consecutive failed checks
entry_len  output  3  digits currently held in the entry register (0..4)
cp  output  16  current stored code

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - State goes to IDLE, entry = 0, entry_len = 0, count = 0, cp = DEFAULT_CODE.
  - unlock, buzzer and lockout = 0, all timers = 0.
  - Reset overrides every state, including OPEN, LOCKOUT and the change states, in the same cycle.
- Registered outputs: all outputs are registered. A response appears the cycle after the sampled key_valid.
- Digit key, entry_len < 4: entry <= {entry[11:0], key_code} and entry_len increments.
- Digit key, entry_len == 4: ignored.
- CLEAR: entry = 0 and entry_len = 0 in any entry-accepting state. Also aborts the change procedure back to IDLE.
- Keys 0xD-0xF are no-ops everywhere.
- States:
  - IDLE/ENTRY: collect digits.
    - ENTER with entry_len == 4: compare entry to cp.
      - Match: go to OPEN and clear count.
      - Mismatch: count increments; if the new count == MAX_FAILS go to LOCKOUT, else stay.
      - In both cases the entry is cleared.
    - ENTER with entry_len < 4: clear the entry only; count is unchanged.
    - CHANGE: go to CHG_OLD with the entry cleared.
  - OPEN:
    - unlock = 1 for exactly OPEN_CYCLES cycles, then return to IDLE.
    - Keys are ignored.
  - LOCKOUT:
    - buzzer = lockout = 1 for exactly LOCKOUT_CYCLES cycles.
    - Keys are ignored.
    - On exit, count = 0 and state returns to IDLE.
  - CHG_OLD: collect 4 digits; ENTER compares them to cp.
    - Match: go to CHG_NEW.
    - Mismatch: counts as a failed check (count increments, may enter LOCKOUT), else return to IDLE.
  - CHG_NEW: collect 4 digits; ENTER latches them as pending code and goes to CHG_CFM.
  - CHG_CFM: collect 4 digits; ENTER compares them to pending code.
    - Match: cp <= pending, go to IDLE.
    - Mismatch: cp is unchanged, go to IDLE; count is not touched.
  - In any CHG_* state, ENTER with entry_len < 4 returns to IDLE with cp unchanged.
- Simultaneity: key_valid is sampled only on the cycle it is high. Timer expiry and a key in the same cycle means the expiry wins and the key is dropped.
- Saturation: count never exceeds MAX_FAILS.

Optional Feature:
LOCK_CTRL_TIMEOUT_EN:
- Defined: an idle counter runs in IDLE and CHG_* whenever entry_len > 0 and no key_valid arrives. It resets on every key. At TIMEOUT_CYCLES it clears the entry; in CHG_* it also returns to IDLE. count is unchanged.
- Undefined: no timeout logic; a partial entry persists indefinitely.

Test Plan:
- Reset, then keys 1,2,3,4,ENTER -> unlock high exactly 8 cycles starting the cycle after ENTER; count = 0.
- Keys 9,9,9,9,ENTER three times -> count goes 1,2,3. Then buzzer = lockout = 1 for 20 cycles, keys during lockout are ignored, and afterwards count = 0.
- Keys 1,2,ENTER -> entry_len 0, count 0, no unlock. Then 1,2,3,4,5,ENTER -> the 5th digit is ignored and unlock fires.
- Change sequence CHANGE,1,2,3,4,ENTER,5,6,7,8,ENTER,5,6,7,8,ENTER -> cp = 16'h5678. A later 1,2,3,4,ENTER increments count; 5,6,7,8,ENTER unlocks.
- Same change sequence with confirm 5,6,7,9 -> cp stays 16'h1234. Reset asserted mid-OPEN -> unlock drops next cycle and cp = DEFAULT_CODE.
- With LOCK_CTRL_TIMEOUT_EN: keys 1,2, then 50 idle cycles -> entry_len = 0. Then 3,4,ENTER -> no unlock and count stays 0 (short entry).
